// File: rtl/steer_pkg.sv
// Shared types and constants for the steering-enable qualifier.
package steer_pkg;

    // Rider FSM: nobody aboard, settling, steering allowed.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEER = 2'd2
    } steer_state_e;

    // Default weight thresholds on the 13-bit load-cell sum.
    localparam logic [11:0] MIN_RIDER_WT_DEF  = 12'h200;
    localparam logic [7:0]  WT_HYSTERESIS_DEF = 8'h40;

    // Settling timer widths: real hardware vs. shortened simulation.
    localparam int TMR_W_NORM = 26;
    localparam int TMR_W_FAST = 15;

    // Magnitude of the left/right imbalance.
    function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/steer_tmr.sv
// Saturating up-counter used as the rider settling timer.
module steer_tmr
    import steer_pkg::*;
#(
    parameter int W = TMR_W_FAST
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic full
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign full = &cnt_q;

    // Clear wins over increment; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !full) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/steer_en.sv
// Rider-presence and steering-enable qualifier driven by the left/right
// load cells. Steering is granted only after the rider has stood evenly
// for a full settling period.
module steer_en
    import steer_pkg::*;
#(
    parameter logic [11:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
    parameter logic [7:0]  WT_HYSTERESIS = WT_HYSTERESIS_DEF,
    parameter bit          FAST_SIM      = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off,
    output logic        tmr_full
);

    localparam int TMR_W = FAST_SIM ? TMR_W_FAST : TMR_W_NORM;

    // Hysteresis thresholds: a rider must exceed THR_HI to be detected,
    // and is only considered gone once the sum falls below THR_LO.
    localparam logic [12:0] THR_HI = {1'b0, MIN_RIDER_WT} + {5'b0, WT_HYSTERESIS};
    localparam logic [12:0] THR_LO = {1'b0, MIN_RIDER_WT} - {5'b0, WT_HYSTERESIS};

    steer_state_e state_q;
    steer_state_e state_d;

    logic [12:0] sum;
    logic [11:0] diff;
    logic        sum_gt_min;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;
    logic        tmr_clr;
    logic        tmr_inc;

    assign sum  = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign diff = abs_diff(lft_ld, rght_ld);

    // Once a rider is detected the lower threshold applies, so a sum
    // inside the band keeps whatever qualifier the current state has.
    assign sum_gt_min    = (state_q == IDLE) ? (sum > THR_HI) : (sum >= THR_LO);
    assign diff_gt_1_4   = {1'b0, diff} > (sum >> 2);
    assign diff_gt_15_16 = {1'b0, diff} > (sum - (sum >> 4));

    steer_tmr #(
        .W(TMR_W)
    ) u_tmr (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .inc (tmr_inc),
        .full(tmr_full)
    );

    // Next-state and timer control; low weight is checked first so it
    // beats any imbalance condition.
    always_comb begin
        state_d = state_q;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_clr = 1'b1;
                if (sum_gt_min) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!sum_gt_min) begin
                    state_d = IDLE;
                end else if (diff_gt_1_4) begin
                    tmr_clr = 1'b1;
                end else if (tmr_full) begin
                    state_d = STEER;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            STEER: begin
                if (!sum_gt_min) begin
                    state_d = IDLE;
                end else if (diff_gt_15_16) begin
                    state_d = WAIT;
                    tmr_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset forces IDLE immediately so the outputs
    // drop steering without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign en_steer  = (state_q == STEER);
    assign rider_off = (state_q == IDLE);

endmodule

// File: tb/tb_steer_en.sv
// Self-checking bench for steer_en (FAST_SIM build) with a behavioural
// rider model kept alongside the DUT.
module tb_steer_en;

    localparam int TMAX   = (1 << 15) - 1;
    localparam int SETTLE = (1 << 15) + 1;

    logic        clk;
    logic        rst;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;
    logic        tmr_full;

    int n_vec;
    int n_err;

    // Reference model: 0 = nobody aboard, 1 = settling, 2 = steering.
    int m_mode;
    int m_tmr;

    steer_en #(
        .FAST_SIM(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .en_steer (en_steer),
        .rider_off(rider_off),
        .tmr_full (tmr_full)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog expired: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance the reference model by one clock using plain arithmetic on
    // the rider rules.
    task automatic model_step(input int l, input int r);
        int  s;
        int  d;
        bit  present;
        s = l + r;
        d = (l > r) ? l - r : r - l;
        present = (m_mode == 0) ? (s > 'h240) : (s >= 'h1C0);
        case (m_mode)
            0: begin
                m_tmr = 0;
                if (present) m_mode = 1;
            end
            1: begin
                if (!present)              m_mode = 0;
                else if (d > s / 4)        m_tmr = 0;
                else if (m_tmr == TMAX)    m_mode = 2;
                else                       m_tmr = m_tmr + 1;
            end
            default: begin
                if (!present) m_mode = 0;
                else if (d > s - s / 16) begin
                    m_mode = 1;
                    m_tmr  = 0;
                end
            end
        endcase
    endtask

    function automatic logic [2:0] model_outs();
        return {m_mode == 2, m_mode == 0, m_tmr == TMAX};
    endfunction

    // One clock with the given loads; outputs are sampled 1 time unit
    // after the active edge.
    task automatic drive(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
        @(posedge clk);
        model_step(int'(l), int'(r));
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lft_ld = '0;
        rght_ld = '0;
        m_mode = 0;
        m_tmr = 0;
        #1;
        n_vec++;
        if ({en_steer, rider_off, tmr_full} !== 3'b010) begin
            n_err++;
            $display("FAIL reset_async en/off/full=%b expected 010", {en_steer, rider_off, tmr_full});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if ({en_steer, rider_off, tmr_full} !== 3'b010) begin
                n_err++;
                $display("FAIL reset_held en/off/full=%b expected 010", {en_steer, rider_off, tmr_full});
            end
        end
        rst = 1'b0;
        drive(12'h000, 12'h000);
        n_vec++;
        if ({en_steer, rider_off, tmr_full} !== 3'b010) begin
            n_err++;
            $display("FAIL reset_release en/off/full=%b expected 010", {en_steer, rider_off, tmr_full});
        end
        $display("test_reset done");
    endtask

    task automatic test_below_threshold();
        for (int i = 0; i < 2000; i++) begin
            drive(12'h100, 12'h139);
            n_vec++;
            if ({en_steer, rider_off, tmr_full} !== model_outs()) begin
                n_err++;
                $display("FAIL below_thr cyc %0d en/off/full=%b expected %b", i, {en_steer, rider_off, tmr_full}, model_outs());
            end
        end
        n_vec++;
        if ({en_steer, rider_off} !== 2'b01) begin
            n_err++;
            $display("FAIL below_thr_final en/off=%b expected 01", {en_steer, rider_off});
        end
        $display("test_below_threshold done: sum 0x239 held 2000 clocks");
    endtask

    // Enter WAIT, disturb the balance for one clock early in the count,
    // then confirm steering arrives a full period after the disturbance.
    task automatic test_settle_restart();
        int t_full;
        int t_en;
        drive(12'h121, 12'h121);
        n_vec++;
        if ({en_steer, rider_off} !== 2'b00) begin
            n_err++;
            $display("FAIL enter_wait en/off=%b expected 00", {en_steer, rider_off});
        end
        for (int i = 2; i <= 100; i++) begin
            drive(12'h121, 12'h121);
            n_vec++;
            if ({en_steer, rider_off, tmr_full} !== model_outs()) begin
                n_err++;
                $display("FAIL wait_count cyc %0d en/off/full=%b expected %b", i, {en_steer, rider_off, tmr_full}, model_outs());
            end
        end
        drive(12'h180, 12'h0A0);
        n_vec++;
        if ({en_steer, rider_off, tmr_full} !== 3'b000) begin
            n_err++;
            $display("FAIL wait_imbalance en/off/full=%b expected 000", {en_steer, rider_off, tmr_full});
        end
        t_full = -1;
        t_en = -1;
        for (int i = 102; i <= 101 + 40000 && t_en < 0; i++) begin
            drive(12'h121, 12'h121);
            n_vec++;
            if ({en_steer, rider_off, tmr_full} !== model_outs()) begin
                n_err++;
                $display("FAIL wait_restart cyc %0d en/off/full=%b expected %b", i, {en_steer, rider_off, tmr_full}, model_outs());
            end
            if (tmr_full && t_full < 0) t_full = i;
            if (en_steer) t_en = i;
        end
        n_vec++;
        if (t_en != 101 + (1 << 15)) begin
            n_err++;
            $display("FAIL restart_latency en_steer at clock %0d expected %0d", t_en, 101 + (1 << 15));
        end
        n_vec++;
        if (t_full != t_en - 1) begin
            n_err++;
            $display("FAIL tmr_full_lead tmr_full at clock %0d expected %0d", t_full, t_en - 1);
        end
        $display("test_settle_restart done: en_steer at clock %0d", t_en);
    endtask

    task automatic test_steer_tolerance();
        for (int i = 0; i < 5; i++) begin
            drive(12'h180, 12'h0E0);
            n_vec++;
            if ({en_steer, rider_off} !== 2'b10) begin
                n_err++;
                $display("FAIL steer_imbalance cyc %0d en/off=%b expected 10", i, {en_steer, rider_off});
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive(12'h0F0, 12'h0F0);
            n_vec++;
            if ({en_steer, rider_off} !== 2'b10) begin
                n_err++;
                $display("FAIL steer_band cyc %0d en/off=%b expected 10", i, {en_steer, rider_off});
            end
        end
        drive(12'h010, 12'h240);
        n_vec++;
        if ({en_steer, rider_off, tmr_full} !== 3'b000) begin
            n_err++;
            $display("FAIL steer_revoke en/off/full=%b expected 000", {en_steer, rider_off, tmr_full});
        end
        $display("test_steer_tolerance done");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 20; i++) begin
            drive(12'h121, 12'h121);
            n_vec++;
            if ({en_steer, rider_off, tmr_full} !== model_outs()) begin
                n_err++;
                $display("FAIL pre_reset cyc %0d en/off/full=%b expected %b", i, {en_steer, rider_off, tmr_full}, model_outs());
            end
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({en_steer, rider_off, tmr_full} !== 3'b010) begin
            n_err++;
            $display("FAIL async_reset en/off/full=%b expected 010", {en_steer, rider_off, tmr_full});
        end
        m_mode = 0;
        m_tmr = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("test_async_reset done");
    endtask

    task automatic test_resteer_and_drop();
        int t_en;
        t_en = -1;
        for (int i = 1; i <= 40000 && t_en < 0; i++) begin
            drive(12'h121, 12'h121);
            n_vec++;
            if ({en_steer, rider_off, tmr_full} !== model_outs()) begin
                n_err++;
                $display("FAIL resteer cyc %0d en/off/full=%b expected %b", i, {en_steer, rider_off, tmr_full}, model_outs());
            end
            if (en_steer) t_en = i;
        end
        n_vec++;
        if (t_en != SETTLE) begin
            n_err++;
            $display("FAIL settle_time en_steer at clock %0d expected %0d", t_en, SETTLE);
        end
        for (int i = 0; i < 4; i++) begin
            drive(12'h0F0, 12'h0F0);
            n_vec++;
            if ({en_steer, rider_off} !== 2'b10) begin
                n_err++;
                $display("FAIL drop_band cyc %0d en/off=%b expected 10", i, {en_steer, rider_off});
            end
        end
        drive(12'h0D0, 12'h0D0);
        n_vec++;
        if ({en_steer, rider_off} !== 2'b01) begin
            n_err++;
            $display("FAIL drop_low en/off=%b expected 01", {en_steer, rider_off});
        end
        $display("test_resteer_and_drop done: en_steer at clock %0d", t_en);
    endtask

    // Loads scattered around the hysteresis band with occasional heavy
    // imbalance in either direction.
    task automatic test_random();
        logic [11:0] l;
        logic [11:0] r;
        int          hold;
        for (int v = 0; v < 600; v++) begin
            if ($urandom_range(0, 7) == 0) begin
                l = 12'($urandom_range(0, 'h300));
                r = 12'($urandom_range(0, 'h60));
                if ($urandom_range(0, 1) == 1) begin
                    {l, r} = {r, l};
                end
            end else begin
                l = 12'($urandom_range('h0C0, 'h140));
                r = 12'($urandom_range('h0C0, 'h140));
            end
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) begin
                drive(l, r);
                n_vec++;
                if ({en_steer, rider_off, tmr_full} !== model_outs()) begin
                    n_err++;
                    $display("FAIL random vec %0d l=%h r=%h en/off/full=%b expected %b", v, l, r, {en_steer, rider_off, tmr_full}, model_outs());
                end
            end
        end
        $display("test_random done: 600 random load vectors");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_below_threshold();
        test_settle_restart();
        test_steer_tolerance();
        test_async_reset();
        test_resteer_and_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
